// File: rtl/cla_arb_pkg.sv
// Shared types and constants for the round-robin controller around the external CLA adder/subtractor.
package cla_arb_pkg;

    localparam int W_DEFAULT = 15;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [W_DEFAULT-1:0] SAT_POS = {1'b0, {(W_DEFAULT-1){1'b1}}};
    localparam logic [W_DEFAULT-1:0] SAT_NEG = {1'b1, {(W_DEFAULT-1){1'b0}}};

    typedef struct packed {
        logic [W_DEFAULT-1:0] a;
        logic [W_DEFAULT-1:0] b;
        logic                 sub;
        logic                 id;
    } operand_t;

    // Overflow direction follows operand A's sign: A+B and A-B can only overflow away from A.
    function automatic logic [W_DEFAULT-1:0] sat_result(input logic [W_DEFAULT-1:0] s,
                                                        input logic ovf,
                                                        input logic a_sign);
        if (!ovf)
            return s;
        return a_sign ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester that was not granted last wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] i_req,
    input  logic       i_hs,
    output logic       o_gnt_id,
    output logic       o_gnt_valid
);

    logic r_last_grant;

    always_comb begin
        o_gnt_valid = |i_req;
        case (i_req)
            2'b01:   o_gnt_id = 1'b0;
            2'b10:   o_gnt_id = 1'b1;
            2'b11:   o_gnt_id = ~r_last_grant;
            default: o_gnt_id = 1'b0;
        endcase
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (srst)
            r_last_grant <= 1'b1;
        else if (i_hs)
            r_last_grant <= o_gnt_id;
    end

endmodule

// File: rtl/cla_addsub_arbiter.sv
// Time-shares one external combinational CLA adder/subtractor between two valid/ready requesters.
// Optional macro CLA_ARB_SATURATE_EN clamps RSP_S on overflow; W must match the package operand width.
module cla_addsub_arbiter
    import cla_arb_pkg::*;
#(
    parameter int W             = W_DEFAULT,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ0_VALID,
    output logic         REQ0_READY,
    input  logic [W-1:0] REQ0_A,
    input  logic [W-1:0] REQ0_B,
    input  logic         REQ0_SUB,
    input  logic         REQ1_VALID,
    output logic         REQ1_READY,
    input  logic [W-1:0] REQ1_A,
    input  logic [W-1:0] REQ1_B,
    input  logic         REQ1_SUB,
    output logic [W-1:0] ADD_A,
    output logic [W-1:0] ADD_B,
    output logic         ADD_SUB,
    input  logic [W-1:0] ADD_S,
    input  logic         ADD_OVF,
    output logic         RSP_VALID,
    output logic         RSP_ID,
    output logic [W-1:0] RSP_S,
    output logic         RSP_OVF,
    output logic         BUSY
);

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    operand_t        r_op;
    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [W-1:0]    r_rsp_s;
    logic            r_rsp_ovf;
    logic            r_busy;

    logic            w_gnt_id;
    logic            w_gnt_valid;
    logic            w_hs;
    logic [W-1:0]    w_rsp_s;

    rr_arb2 u_rr_arb2 (
        .clk         (CLK),
        .srst        (RST),
        .i_req       ({REQ1_VALID, REQ0_VALID}),
        .i_hs        (w_hs),
        .o_gnt_id    (w_gnt_id),
        .o_gnt_valid (w_gnt_valid)
    );

    // Handshake is suppressed while reset is asserted so READY stays low with the other outputs.
    assign w_hs       = (r_state == IDLE) && w_gnt_valid && !RST;
    assign REQ0_READY = w_hs && !w_gnt_id;
    assign REQ1_READY = w_hs &&  w_gnt_id;

`ifdef CLA_ARB_SATURATE_EN
    assign w_rsp_s = sat_result(ADD_S, ADD_OVF, r_op.a[W-1]);
`else
    assign w_rsp_s = ADD_S;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_s     <= '0;
            r_rsp_ovf   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (w_hs) begin
                        r_op <= '{a:   w_gnt_id ? REQ1_A   : REQ0_A,
                                  b:   w_gnt_id ? REQ1_B   : REQ0_B,
                                  sub: w_gnt_id ? REQ1_SUB : REQ0_SUB,
                                  id:  w_gnt_id};
                        r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    // Adder inputs have been stable for SETTLE_CYCLES once the counter reaches zero.
                    if (r_cnt == '0) begin
                        r_rsp_s     <= w_rsp_s;
                        r_rsp_ovf   <= ADD_OVF;
                        r_rsp_id    <= r_op.id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ADD_A     = r_op.a;
    assign ADD_B     = r_op.b;
    assign ADD_SUB   = r_op.sub;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_ID    = r_rsp_id;
    assign RSP_S     = r_rsp_s;
    assign RSP_OVF   = r_rsp_ovf;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_cla_addsub_arbiter.sv
// Self-checking bench for cla_addsub_arbiter with a behavioural model of the shared adder.
module tb_cla_addsub_arbiter;

    localparam int W  = 15;
    localparam int ST = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic          REQ0_READY, REQ1_READY;
    logic [W-1:0]  REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
    logic          REQ0_SUB = 1'b0, REQ1_SUB = 1'b0;
    logic [W-1:0]  ADD_A, ADD_B, ADD_S;
    logic          ADD_SUB, ADD_OVF;
    logic          RSP_VALID, RSP_ID, RSP_OVF, BUSY;
    logic [W-1:0]  RSP_S;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    cla_addsub_arbiter #(.W(W), .SETTLE_CYCLES(ST)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_SUB(REQ0_SUB),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_SUB(REQ1_SUB),
        .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_SUB(ADD_SUB), .ADD_S(ADD_S), .ADD_OVF(ADD_OVF),
        .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_S(RSP_S), .RSP_OVF(RSP_OVF), .BUSY(BUSY)
    );

    // External adder: exact integer result, wrapped to 15 bits, overflow when out of signed range.
    function automatic logic [15:0] adder_model(input logic [14:0] a, input logic [14:0] b, input logic sub);
        int sa, sb, r;
        logic [14:0] s;
        logic ovf;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        r   = sub ? (sa - sb) : (sa + sb);
        ovf = (r > 16383) || (r < -16384);
        s   = r[14:0];
        return {ovf, s};
    endfunction

    // Expected response as seen on RSP_S/RSP_OVF, including clamping when that build option is on.
    function automatic logic [15:0] expect_rsp(input logic [14:0] a, input logic [14:0] b, input logic sub);
        int sa, sb, r;
        logic [14:0] s;
        logic ovf;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        r   = sub ? (sa - sb) : (sa + sb);
        ovf = (r > 16383) || (r < -16384);
        s   = r[14:0];
`ifdef CLA_ARB_SATURATE_EN
        if (ovf) s = (r > 0) ? 15'h3FFF : 15'h4000;
`endif
        return {ovf, s};
    endfunction

    assign {ADD_OVF, ADD_S} = adder_model(ADD_A, ADD_B, ADD_SUB);

    task automatic apply_reset();
        @(negedge CLK);
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // Drives one operation, returns the response and cycles from the handshake cycle to RSP_VALID.
    task automatic run_op(input logic id, input logic [14:0] a, input logic [14:0] b, input logic sub,
                          output logic [14:0] s, output logic ovf, output logic rid,
                          output int lat, output bit timed_out);
        int n;
        bit got;
        s = '0; ovf = 1'b0; rid = 1'b0; lat = 0; timed_out = 1'b1;
        @(negedge CLK);
        if (id) begin REQ1_A = a; REQ1_B = b; REQ1_SUB = sub; REQ1_VALID = 1'b1; end
        else    begin REQ0_A = a; REQ0_B = b; REQ0_SUB = sub; REQ0_VALID = 1'b1; end
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            #1;
            if (id ? REQ1_READY : REQ0_READY) got = 1'b1;
            else begin @(negedge CLK); n++; end
        end
        if (!got) begin
            REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        if (id) REQ1_VALID = 1'b0; else REQ0_VALID = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge CLK);
            n++;
            if (RSP_VALID) begin got = 1'b1; s = RSP_S; ovf = RSP_OVF; rid = RSP_ID; end
        end
        lat = n;
        timed_out = !got;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        REQ0_VALID = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({ADD_A, ADD_B, ADD_SUB} !== '0) begin
            errors++; $display("FAIL reset_add got %0h want 0", {ADD_A, ADD_B, ADD_SUB});
        end
        checks++;
        if ({RSP_VALID, RSP_ID, RSP_S, RSP_OVF, BUSY} !== '0) begin
            errors++; $display("FAIL reset_rsp got %0h want 0", {RSP_VALID, RSP_ID, RSP_S, RSP_OVF, BUSY});
        end
        checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b want 00", {REQ0_READY, REQ1_READY});
        end
        REQ0_VALID = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_add_ovf();
        logic [14:0] s; logic ovf, rid; int lat; bit to;
        logic [14:0] want;
`ifdef CLA_ARB_SATURATE_EN
        want = 15'h3FFF;
`else
        want = 15'h4A3E;
`endif
        run_op(1'b0, 15'd9650, 15'd9356, 1'b0, s, ovf, rid, lat, to);
        $display("op req0 9650+9356 -> s=%0h ovf=%0b id=%0b lat=%0d", s, ovf, rid, lat);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL add_ovf_timeout got %0b want 0", to); end
        checks++;
        if (lat != ST + 1) begin errors++; $display("FAIL add_ovf_latency got %0d want %0d", lat, ST + 1); end
        checks++;
        if (rid !== 1'b0) begin errors++; $display("FAIL add_ovf_id got %0b want 0", rid); end
        checks++;
        if (s !== want) begin errors++; $display("FAIL add_ovf_s got %0h want %0h", s, want); end
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL add_ovf_flag got %0b want 1", ovf); end
    endtask

    task automatic test_tie();
        int n, nrsp, first;
        bit both;
        logic r0, r1;
        logic [14:0] rs [2];
        logic ro [2];
        logic ri [2];
        apply_reset();
        @(negedge CLK);
        REQ0_A = 15'd8431; REQ0_B = 15'd1534; REQ0_SUB = 1'b0; REQ0_VALID = 1'b1;
        REQ1_A = 15'd4181; REQ1_B = 15'h7C18; REQ1_SUB = 1'b1; REQ1_VALID = 1'b1;
        n = 0; nrsp = 0; first = -1; both = 1'b0;
        while (nrsp < 2 && n < 60) begin
            #1;
            r0 = REQ0_READY; r1 = REQ1_READY;
            if (r0 && r1) both = 1'b1;
            if (first < 0) begin
                if (r0) first = 0; else if (r1) first = 1;
            end
            if (RSP_VALID) begin
                rs[nrsp] = RSP_S; ro[nrsp] = RSP_OVF; ri[nrsp] = RSP_ID;
                $display("op tie rsp%0d id=%0b s=%0d ovf=%0b", nrsp, RSP_ID, RSP_S, RSP_OVF);
                nrsp++;
            end
            @(posedge CLK);
            #1;
            if (r0) REQ0_VALID = 1'b0;
            if (r1) REQ1_VALID = 1'b0;
            @(negedge CLK);
            n++;
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        checks++;
        if (nrsp != 2) begin errors++; $display("FAIL tie_count got %0d want 2", nrsp); end
        checks++;
        if (first != 0) begin errors++; $display("FAIL tie_first_grant got %0d want 0", first); end
        checks++;
        if (both !== 1'b0) begin errors++; $display("FAIL tie_both_ready got %0b want 0", both); end
        if (nrsp == 2) begin
            checks++;
            if ({ri[0], ro[0], rs[0]} !== {1'b0, 1'b0, 15'd9965}) begin
                errors++; $display("FAIL tie_rsp0 got id=%0b ovf=%0b s=%0d want id=0 ovf=0 s=9965", ri[0], ro[0], rs[0]);
            end
            checks++;
            if ({ri[1], ro[1], rs[1]} !== {1'b1, 1'b0, 15'd5181}) begin
                errors++; $display("FAIL tie_rsp1 got id=%0b ovf=%0b s=%0d want id=1 ovf=0 s=5181", ri[1], ro[1], rs[1]);
            end
        end
    endtask

    task automatic test_sub_neg_ovf();
        logic [14:0] s, a, want; logic ovf, rid; int lat; bit to;
        int na;
        na = -9485;
        a  = na[14:0];
`ifdef CLA_ARB_SATURATE_EN
        want = 15'h4000;
`else
        want = 15'd13497;
`endif
        run_op(1'b1, a, 15'd9786, 1'b1, s, ovf, rid, lat, to);
        $display("op req1 -9485-9786 -> s=%0d ovf=%0b id=%0b lat=%0d", s, ovf, rid, lat);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL sub_ovf_timeout got %0b want 0", to); end
        checks++;
        if (rid !== 1'b1) begin errors++; $display("FAIL sub_ovf_id got %0b want 1", rid); end
        checks++;
        if (s !== want) begin errors++; $display("FAIL sub_ovf_s got %0h want %0h", s, want); end
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL sub_ovf_flag got %0b want 1", ovf); end
    endtask

    task automatic test_back_to_back();
        logic [14:0] ta [3];
        logic [14:0] tb_b [3];
        logic        tsub [3];
        int          rc [3];
        logic [15:0] rv [3];
        logic        rid [3];
        int n, nr, k, cur;
        logic r1;
        logic [15:0] want;
        for (int i = 0; i < 3; i++) begin
            ta[i] = 15'($urandom()); tb_b[i] = 15'($urandom()); tsub[i] = 1'($urandom());
        end
        @(negedge CLK);
        REQ1_A = ta[0]; REQ1_B = tb_b[0]; REQ1_SUB = tsub[0]; REQ1_VALID = 1'b1;
        n = 0; nr = 0; k = 0; cur = -1;
        while (nr < 3 && n < 80) begin
            #1;
            r1 = REQ1_READY;
            if (RSP_VALID && nr < 3) begin
                rc[nr] = n; rv[nr] = {RSP_OVF, RSP_S}; rid[nr] = RSP_ID;
                $display("op b2b rsp%0d cycle=%0d id=%0b s=%0h ovf=%0b", nr, n, RSP_ID, RSP_S, RSP_OVF);
                nr++;
            end else if (BUSY && cur >= 0) begin
                checks++;
                if ({ADD_A, ADD_B, ADD_SUB} !== {ta[cur], tb_b[cur], tsub[cur]}) begin
                    errors++;
                    $display("FAIL b2b_add_stable got %0h/%0h/%0b want %0h/%0h/%0b",
                             ADD_A, ADD_B, ADD_SUB, ta[cur], tb_b[cur], tsub[cur]);
                end
            end
            @(posedge CLK);
            #1;
            if (r1) begin
                cur = k;
                k++;
                if (k < 3) begin REQ1_A = ta[k]; REQ1_B = tb_b[k]; REQ1_SUB = tsub[k]; end
                else REQ1_VALID = 1'b0;
            end
            @(negedge CLK);
            n++;
        end
        REQ1_VALID = 1'b0;
        checks++;
        if (nr != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", nr); end
        if (nr == 3) begin
            for (int i = 0; i < 3; i++) begin
                want = expect_rsp(ta[i], tb_b[i], tsub[i]);
                checks++;
                if ({rid[i], rv[i]} !== {1'b1, want}) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d got id=%0b %0h want id=1 %0h", i, rid[i], rv[i], want);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (rc[i] - rc[i-1] != ST + 2) begin
                    errors++; $display("FAIL b2b_spacing got %0d want %0d", rc[i] - rc[i-1], ST + 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit got, seen;
        @(negedge CLK);
        REQ0_A = 15'd100; REQ0_B = 15'd200; REQ0_SUB = 1'b0; REQ0_VALID = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            #1;
            if (REQ0_READY) got = 1'b1;
            else begin @(negedge CLK); n++; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rstmid_grant got timeout want ready"); end
        @(posedge CLK);
        #1 REQ0_VALID = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        $display("op reset asserted in second EXEC cycle");
        checks++;
        if ({ADD_A, ADD_B, ADD_SUB, RSP_VALID, RSP_ID, RSP_S, RSP_OVF, BUSY} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got %0h want 0", {ADD_A, ADD_B, ADD_SUB, RSP_VALID, RSP_ID, RSP_S, RSP_OVF, BUSY});
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (RSP_VALID) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp got %0b want 0", seen); end
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        #1;
        checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
            errors++; $display("FAIL rstmid_tie_grant got %b want 10", {REQ0_READY, REQ1_READY});
        end
        #1;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    endtask

    task automatic test_random();
        logic [14:0] a, b, s; logic sub, id, ovf, rid; int lat; bit to;
        logic [15:0] want;
        for (int i = 0; i < 16; i++) begin
            a = 15'($urandom()); b = 15'($urandom()); sub = 1'($urandom()); id = 1'($urandom());
            want = expect_rsp(a, b, sub);
            run_op(id, a, b, sub, s, ovf, rid, lat, to);
            $display("op rand%0d id=%0b a=%0h b=%0h sub=%0b -> s=%0h ovf=%0b lat=%0d", i, id, a, b, sub, s, ovf, lat);
            checks++;
            if ({to, rid, ovf, s} !== {1'b0, id, want}) begin
                errors++;
                $display("FAIL rand%0d got to=%0b id=%0b %0h want to=0 id=%0b %0h", i, to, rid, {ovf, s}, id, want);
            end
            checks++;
            if (lat != ST + 1) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, ST + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_tie();
        test_sub_neg_ovf();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
